ex_stage_control: RTL and testbench

EX_STAGE_CONTROL -- requirements
Module: ex_stage_control

---
 rtl/ex_stage_control_pkg.sv | 71 +++++++
 rtl/ex_stage_control_if.sv | 36 +++
 rtl/ex_stage_control_muldiv_seq.sv | 66 ++++++
 rtl/ex_stage_control.sv | 118 +++++++++++
 tb/tb_ex_stage_control.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_control_pkg.sv
// Shared RV32 opcode, funct and ALU-select constants for the execute-stage control slice.
package ex_stage_control_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Wide enough for the largest legal MULDIV_CYCLES-1 (31).
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SLL    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_XOR    = 4'd4,
    ALU_SRL    = 4'd5,
    ALU_OR     = 4'd6,
    ALU_AND    = 4'd7,
    ALU_SLTU   = 4'd11,
    ALU_SUB    = 4'd12,
    ALU_SRA    = 4'd13,
    ALU_PASS_B = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  // bit30 selects SUB only for register-register ops; it selects SRA for both shapes.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic bit30,
                                         input logic is_r);
    alu_op_e op;
    case (funct3)
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR: begin
        if (bit30) op = ALU_SRA;
        else       op = ALU_SRL;
      end
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: begin
        if (is_r && bit30) op = ALU_SUB;
        else               op = ALU_ADD;
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_control_if.sv
// Bundle of s1->s2 inputs, forwarding info and s2 decode/sequencer outputs.
interface ex_stage_control_if;
  logic [31:0] inst_in;
  logic        valid_in;
  logic        flush;
  logic        stall_ext;
  logic [4:0]  rd_s3;
  logic        regwen_s3;
  logic [31:0] inst_s2;
  logic        valid_s2;
  logic [1:0]  rs1_sel;
  logic [1:0]  rs2_sel;
  logic        brun;
  logic        a_sel;
  logic        b_sel;
  logic        mem_wen;
  logic        regwen_s2;
  logic [3:0]  alu_sel;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_done;
  logic        stall_s1;
  logic        illegal_s2;

  modport master (
    output inst_in, valid_in, flush, stall_ext, rd_s3, regwen_s3,
    input  inst_s2, valid_s2, rs1_sel, rs2_sel, brun, a_sel, b_sel, mem_wen, regwen_s2,
           alu_sel, md_start, md_op, md_done, stall_s1, illegal_s2
  );

  modport slave (
    input  inst_in, valid_in, flush, stall_ext, rd_s3, regwen_s3,
    output inst_s2, valid_s2, rs1_sel, rs2_sel, brun, a_sel, b_sel, mem_wen, regwen_s2,
           alu_sel, md_start, md_op, md_done, stall_s1, illegal_s2
  );
endinterface

// File: rtl/ex_stage_control_muldiv_seq.sv
// Multi-cycle M-op sequencer: launch pulse, busy countdown, and a done state held under stall_ext.
module muldiv_seq
  import ex_stage_control_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch_req,
  input  logic flush,
  input  logic stall_ext,
  output logic md_start,
  output logic md_done,
  output logic stall_s1
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // BUSY leaves on the cycle the counter would reach zero, so launch plus BUSY spans MULDIV_CYCLES.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    stall_s1 = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (launch_req && !flush) begin
          md_start = 1'b1;
          stall_s1 = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = MD_CNT_W'(MULDIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        stall_s1 = 1'b1;
        cnt_d    = cnt_q - MD_CNT_W'(1);
        if (cnt_q <= MD_CNT_W'(1)) begin
          state_d = MD_DONE;
          cnt_d   = '0;
        end
      end
      MD_DONE: begin
        md_done = 1'b1;
        if (!stall_ext) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/ex_stage_control.sv
// Execute-stage control: s2 pipeline register, RV32I/M decode, s3 forwarding select, M-op sequencing.
module ex_stage_control
  import ex_stage_control_pkg::*;
#(
  parameter int unsigned MULDIV_EN     = 1,
  parameter int unsigned MULDIV_CYCLES = 8,
  parameter logic [31:0] NOP_INST      = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  ex_stage_control_if.slave   bus
);

  logic [31:0] inst_q;
  logic        valid_q;
  logic        stall_s1;
  logic        md_start;
  logic        md_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (!(bus.stall_ext || stall_s1)) begin
      inst_q  <= bus.inst_in;
      valid_q <= bus.valid_in;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  alu_op_e    alu_op;
  logic       a_sel, b_sel, store, writes_rd, illegal, is_mop;

  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign funct7 = inst_q[31:25];

  always_comb begin
    alu_op    = ALU_ADD;
    a_sel     = 1'b0;
    b_sel     = 1'b1;
    store     = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    is_mop    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_op    = ALU_PASS_B;
        writes_rd = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        a_sel     = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: a_sel = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: writes_rd = 1'b1;
      OPC_STORE:  store = 1'b1;
      OPC_OP_IMM: begin
        alu_op    = alu_decode(funct3, inst_q[30], 1'b0);
        writes_rd = 1'b1;
      end
      OPC_OP: begin
        b_sel = 1'b0;
        if (funct7 == F7_MULDIV) begin
          if (MULDIV_EN != 0) begin
            is_mop    = 1'b1;
            writes_rd = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          alu_op    = alu_decode(funct3, inst_q[30], 1'b1);
          writes_rd = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  muldiv_seq #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch_req (valid_q && is_mop),
    .flush      (bus.flush),
    .stall_ext  (bus.stall_ext),
    .md_start   (md_start),
    .md_done    (md_done),
    .stall_s1   (stall_s1)
  );

  assign bus.inst_s2    = inst_q;
  assign bus.valid_s2   = valid_q;
  assign bus.alu_sel    = alu_op;
  assign bus.a_sel      = a_sel;
  assign bus.b_sel      = b_sel;
  assign bus.brun       = inst_q[13];
  assign bus.mem_wen    = valid_q && store;
  assign bus.regwen_s2  = valid_q && writes_rd && (rd != '0);
  assign bus.illegal_s2 = valid_q && illegal;
  assign bus.rs1_sel    = (bus.regwen_s3 && (bus.rd_s3 != '0) && (bus.rd_s3 == rs1)) ? 2'b01 : 2'b00;
  assign bus.rs2_sel    = (bus.regwen_s3 && (bus.rd_s3 != '0) && (bus.rd_s3 == rs2)) ? 2'b01 : 2'b00;
  assign bus.md_start   = md_start;
  assign bus.md_op      = funct3;
  assign bus.md_done    = md_done;
  assign bus.stall_s1   = stall_s1;

endmodule

// File: tb/tb_ex_stage_control.sv
// Directed bench for ex_stage_control: decode scoreboard, M-op sequencing, flush and reset behaviour.
module tb_ex_stage_control;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] MUL   = 32'h0220_8033;
  localparam logic [31:0] DIVU  = 32'h0220_D033;
  localparam logic [31:0] ADDI5 = 32'h0050_0093;
  localparam logic [31:0] ADDIA = 32'h00A0_0113;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_stage_control_if bus ();
  ex_stage_control_if bus_n ();

  ex_stage_control #(
    .MULDIV_EN     (1),
    .MULDIV_CYCLES (8),
    .NOP_INST      (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ex_stage_control #(
    .MULDIV_EN     (0),
    .MULDIV_CYCLES (8),
    .NOP_INST      (NOP)
  ) dut_nomd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  assign bus_n.inst_in   = bus.inst_in;
  assign bus_n.valid_in  = bus.valid_in;
  assign bus_n.flush     = bus.flush;
  assign bus_n.stall_ext = bus.stall_ext;
  assign bus_n.rd_s3     = bus.rd_s3;
  assign bus_n.regwen_s3 = bus.regwen_s3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic [3:0]  alu;
    logic        a_sel, b_sel, mem_wen, regwen, illegal, brun;
    logic [1:0]  rs1, rs2;
  } dec_exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  op;
  } md_exp_t;

  dec_exp_t dq[$];
  md_exp_t  mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic vld);
    bus.inst_in  = inst;
    bus.valid_in = vld;
  endtask

  task automatic issue(input logic [31:0] inst, input logic vld, input logic rw3,
                       input logic [4:0] rd3, input logic [3:0] alu, input logic a,
                       input logic b, input logic mw, input logic rw, input logic ill,
                       input logic br, input logic [1:0] r1, input logic [1:0] r2);
    dec_exp_t e;
    drive(inst, vld);
    bus.regwen_s3 = rw3;
    bus.rd_s3     = rd3;
    e.inst = inst;  e.valid = vld;  e.alu = alu;  e.a_sel = a;  e.b_sel = b;
    e.mem_wen = mw; e.regwen = rw;  e.illegal = ill; e.brun = br; e.rs1 = r1; e.rs2 = r2;
    dq.push_back(e);
  endtask

  task automatic retire(input string t);
    dec_exp_t e;
    chk({t, "_sb_depth"}, dq.size(), 1);
    if (dq.size() == 0) return;
    e = dq.pop_front();
    chk({t, "_inst"},    bus.inst_s2,    e.inst);
    chk({t, "_valid"},   bus.valid_s2,   e.valid);
    chk({t, "_alu"},     bus.alu_sel,    e.alu);
    chk({t, "_a_sel"},   bus.a_sel,      e.a_sel);
    chk({t, "_b_sel"},   bus.b_sel,      e.b_sel);
    chk({t, "_mem_wen"}, bus.mem_wen,    e.mem_wen);
    chk({t, "_regwen"},  bus.regwen_s2,  e.regwen);
    chk({t, "_illegal"}, bus.illegal_s2, e.illegal);
    chk({t, "_brun"},    bus.brun,       e.brun);
    chk({t, "_rs1_sel"}, bus.rs1_sel,    e.rs1);
    chk({t, "_rs2_sel"}, bus.rs2_sel,    e.rs2);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_inst"},     bus.inst_s2,    NOP);
    chk({t, "_valid"},    bus.valid_s2,   1'b0);
    chk({t, "_stall_s1"}, bus.stall_s1,   1'b0);
    chk({t, "_md_start"}, bus.md_start,   1'b0);
    chk({t, "_md_done"},  bus.md_done,    1'b0);
    chk({t, "_mem_wen"},  bus.mem_wen,    1'b0);
    chk({t, "_regwen"},   bus.regwen_s2,  1'b0);
    chk({t, "_illegal"},  bus.illegal_s2, 1'b0);
    chk({t, "_alu"},      bus.alu_sel,    4'd0);
    chk({t, "_rs1_sel"},  bus.rs1_sel,    2'b00);
    chk({t, "_rs2_sel"},  bus.rs2_sel,    2'b00);
  endtask

  // Steps from the launch cycle until md_done; cyc counts the launch cycle as 1.
  task automatic run_to_done(input string t, input logic [31:0] inst, output int cyc,
                             output int stalls, output bit seen);
    cyc = 1; stalls = 1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      cyc++;
      if (bus.md_done) seen = 1'b1;
      else begin
        if (bus.stall_s1) stalls++;
        chk({t, "_busy_hold"},  bus.inst_s2,  inst);
        chk({t, "_busy_start"}, bus.md_start, 1'b0);
      end
    end
    chk({t, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic retire_md(input string t);
    md_exp_t m;
    chk({t, "_md_sb_depth"}, mq.size(), 1);
    if (mq.size() == 0) return;
    m = mq.pop_front();
    chk({t, "_md_inst"}, bus.inst_s2, m.inst);
    chk({t, "_md_op"},   bus.md_op,   m.op);
  endtask

  initial begin
    int cyc, stalls, done_cnt;
    bit seen;
    md_exp_t m;

    rst_n = 1'b1;
    bus.inst_in = '0; bus.valid_in = 1'b0; bus.flush = 1'b0;
    bus.stall_ext = 1'b0; bus.rd_s3 = '0; bus.regwen_s3 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    //     inst          vld  rw3  rd3  alu    a  b  mw rw il br  rs1    rs2
    issue(ADDI5,         1, 1'b0, 5'd0, 4'd0,  0, 1, 0, 1, 0, 0, 2'b00, 2'b00); step(); retire("addi");
    issue(32'h40308133,  1, 1'b1, 5'd1, 4'd12, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00); step(); retire("sub_fwd");
    issue(32'h4050D093,  1, 1'b1, 5'd1, 4'd13, 0, 1, 0, 1, 0, 0, 2'b01, 2'b00); step(); retire("srai");
    issue(32'h40000093,  1, 1'b1, 5'd1, 4'd0,  0, 1, 0, 1, 0, 0, 2'b00, 2'b00); step(); retire("addi_b30");
    issue(32'h00512423,  1, 1'b1, 5'd5, 4'd0,  0, 1, 1, 0, 0, 1, 2'b00, 2'b01); step(); retire("sw_fwd2");
    issue(32'h123453B7,  1, 1'b0, 5'd0, 4'd15, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00); step(); retire("lui");
    issue(32'h0020E063,  1, 1'b0, 5'd0, 4'd0,  1, 1, 0, 0, 0, 1, 2'b00, 2'b00); step(); retire("bltu");
    issue(32'h000000EF,  1, 1'b0, 5'd0, 4'd0,  1, 1, 0, 1, 0, 0, 2'b00, 2'b00); step(); retire("jal_x1");
    issue(32'h0000006F,  1, 1'b0, 5'd0, 4'd0,  1, 1, 0, 0, 0, 0, 2'b00, 2'b00); step(); retire("jal_x0");
    issue(32'h0000007F,  1, 1'b0, 5'd0, 4'd0,  0, 1, 0, 0, 1, 0, 2'b00, 2'b00); step(); retire("illegal");
    issue(32'h00512423,  0, 1'b0, 5'd0, 4'd0,  0, 1, 0, 0, 0, 1, 2'b00, 2'b00); step(); retire("sw_invalid");
    issue(32'h00313233,  1, 1'b0, 5'd0, 4'd11, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00); step(); retire("sltu");
    issue(32'h00001297,  1, 1'b0, 5'd0, 4'd0,  1, 1, 0, 1, 0, 0, 2'b00, 2'b00); step(); retire("auipc");

    // MUL: launch cycle, 7 BUSY cycles, DONE on the 9th, then the queued ADDI enters s2.
    issue(MUL,           1, 1'b0, 5'd0, 4'd0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    m.inst = MUL; m.op = 3'b000; mq.push_back(m);
    step(); retire("mul");
    chk("mul_md_start",     bus.md_start,     1'b1);
    chk("mul_launch_stall", bus.stall_s1,     1'b1);
    chk("nomd_illegal",     bus_n.illegal_s2, 1'b1);
    chk("nomd_md_start",    bus_n.md_start,   1'b0);
    chk("nomd_stall",       bus_n.stall_s1,   1'b0);
    drive(ADDI5, 1'b1);
    run_to_done("mul", MUL, cyc, stalls, seen);
    chk("mul_stall_cycles", stalls, 8);
    chk("mul_done_cycle",   cyc,    9);
    chk("mul_done_stall",   bus.stall_s1, 1'b0);
    retire_md("mul");
    step();
    chk("mul_next_inst",  bus.inst_s2,  ADDI5);
    chk("mul_next_valid", bus.valid_s2, 1'b1);
    chk("mul_next_done",  bus.md_done,  1'b0);

    // DIVU with stall_ext held for two DONE cycles.
    drive(DIVU, 1'b1);
    m.inst = DIVU; m.op = 3'b101; mq.push_back(m);
    step();
    chk("divu_md_start", bus.md_start, 1'b1);
    drive(ADDIA, 1'b1);
    run_to_done("divu", DIVU, cyc, stalls, seen);
    retire_md("divu");
    done_cnt = bus.md_done ? 1 : 0;
    bus.stall_ext = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.md_done) done_cnt++;
      chk("divu_stall_hold", bus.inst_s2, DIVU);
    end
    bus.stall_ext = 1'b0;
    step();
    chk("divu_done_cycles", done_cnt,     3);
    chk("divu_done_clear",  bus.md_done,  1'b0);
    chk("divu_next_inst",   bus.inst_s2,  ADDIA);

    // Flush in the third BUSY cycle.
    drive(MUL, 1'b1);
    step();
    chk("fl_md_start", bus.md_start, 1'b1);
    drive(ADDI5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_busy_stall", bus.stall_s1, 1'b1);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_stall",   bus.stall_s1, 1'b0);
    chk("fl_valid",   bus.valid_s2, 1'b0);
    chk("fl_inst",    bus.inst_s2,  NOP);
    chk("fl_md_done", bus.md_done,  1'b0);
    step();
    chk("fl_next_inst",  bus.inst_s2,  ADDI5);
    chk("fl_next_done",  bus.md_done,  1'b0);
    chk("fl_next_stall", bus.stall_s1, 1'b0);

    // Flush in the launch cycle suppresses md_start.
    drive(MUL, 1'b1);
    step();
    chk("sfl_pre_start", bus.md_start, 1'b1);
    bus.flush = 1'b1;
    #1;
    chk("sfl_md_start", bus.md_start, 1'b0);
    chk("sfl_stall",    bus.stall_s1, 1'b0);
    drive(ADDI5, 1'b1);
    step();
    bus.flush = 1'b0;
    chk("sfl_valid", bus.valid_s2, 1'b0);
    chk("sfl_inst",  bus.inst_s2,  NOP);
    step();
    chk("sfl_done",       bus.md_done,  1'b0);
    chk("sfl_next_inst",  bus.inst_s2,  ADDI5);
    chk("sfl_next_stall", bus.stall_s1, 1'b0);

    // Asynchronous reset mid-BUSY: outputs drop at once and the M-op never completes.
    drive(MUL, 1'b1);
    step();
    drive(ADDI5, 1'b1);
    step();
    step();
    chk("rst_pre_stall", bus.stall_s1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.md_done) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_next_inst", bus.inst_s2, ADDI5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

endmodule
